// File: rtl/uart_frame_decoder.sv
// Framed-packet extractor for the UART byte stream: SYNC, LEN, payload, CSUM.
// Payload is staged speculatively and becomes visible on the output only after a checksum match.
module uart_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned BUF_DEPTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ErrBadLen  = 2'd0;
    localparam logic [1:0] ErrBadCsum = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrNoSpace = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StCsum,
        StDrop
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_spec_q, wr_spec_d;
    logic [7:0]    sum_q, sum_d;
    logic [8:0]    rem_q, rem_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic [8:0]    mem_q [BUF_DEPTH];
    logic          mem_we;
    logic [8:0]    mem_wdata;
    logic [8:0]    rd_entry;

    logic [PW-1:0] occupancy;
    logic [PW-1:0] free;
    logic          pop;
    logic          expire;
    logic [7:0]    csum_total;

    // Committed region is [rd_ptr, wr_ptr); speculative bytes live in [wr_ptr, wr_spec).
    always_comb begin
        occupancy  = wr_ptr_q - rd_ptr_q;
        free       = PW'(BUF_DEPTH) - (wr_spec_q - rd_ptr_q);
        out_valid  = (occupancy != '0);
        pop        = out_valid && out_ready;
        rd_entry   = mem_q[rd_ptr_q[AW-1:0]];
        out_data   = rd_entry[7:0];
        out_last   = rd_entry[8];
        csum_total = sum_q + in_data;
        expire     = (state_q != StIdle) && !in_valid &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        wr_spec_d   = wr_spec_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        timer_d     = (in_valid || state_q == StIdle) ? '0 : timer_q + TW'(1);
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        mem_we      = 1'b0;
        mem_wdata   = {(rem_q == 9'd1), in_data};

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_data == SYNC_BYTE) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (in_valid) begin
                    sum_d = in_data;
                    rem_d = {1'b0, in_data};
                    if (in_data == 8'd0 || 32'(in_data) > MAX_LEN) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ErrBadLen;
                        state_d     = StIdle;
                    end else if (32'(in_data) > 32'(free)) begin
                        // Swallow the payload and checksum so they are not mistaken for SYNC.
                        frame_err_d = 1'b1;
                        err_code_d  = ErrNoSpace;
                        rem_d       = {1'b0, in_data} + 9'd1;
                        state_d     = StDrop;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (in_valid) begin
                    mem_we    = 1'b1;
                    wr_spec_d = wr_spec_q + PW'(1);
                    sum_d     = csum_total;
                    rem_d     = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (in_valid) begin
                    if (csum_total == 8'd0) begin
                        wr_ptr_d   = wr_spec_q;
                        frame_ok_d = 1'b1;
                    end else begin
                        wr_spec_d   = wr_ptr_q;
                        frame_err_d = 1'b1;
                        err_code_d  = ErrBadCsum;
                    end
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (in_valid) begin
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled sender abandons the frame; a DROP already reported its error.
        if (expire) begin
            state_d   = StIdle;
            wr_spec_d = wr_ptr_q;
            if (state_q != StDrop) begin
                frame_err_d = 1'b1;
                err_code_d  = ErrTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wr_spec_q   <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            timer_q     <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ErrBadLen;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_spec_q   <= wr_spec_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            timer_q     <= timer_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_spec_q[AW-1:0]] <= mem_wdata;
        end
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: fixed vectors, hand-written corner sequences,
// then random frames checked against a frame-level reference model.
module tb_uart_frame_decoder;

    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam int unsigned MAXL  = 16;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned TO    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_decoder #(
        .SYNC_BYTE      (SYNC),
        .MAX_LEN        (MAXL),
        .BUF_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         ok_seen = 0;
    int         err_seen = 0;
    logic [8:0] exp_q[$];   // expected {last,data} in output order
    logic [7:0] tx_q[$];    // bytes of the frame being sent
    logic [1:0] exp_code = 2'd0;
    bit         rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tx(input int max_gap);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (max_gap > 0 && i != tx_q.size() - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    // Reference model: a good frame's payload is appended to the expected output stream.
    task automatic build_frame(input int len, input bit bad_csum);
        logic [7:0] s;
        logic [7:0] b;
        logic [7:0] csum;
        tx_q.delete();
        tx_q.push_back(SYNC);
        tx_q.push_back(8'(len));
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            tx_q.push_back(b);
            s = s + b;
            if (!bad_csum) exp_q.push_back({(i == len - 1), b});
        end
        csum = 8'h00 - s;
        if (bad_csum) csum = csum ^ 8'($urandom_range(1, 255));
        tx_q.push_back(csum);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            idle(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no output", {out_last, out_data});
                end else begin
                    check("out_byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      name;
        int         nin;
        logic [7:0] din [8];
        int         nout;
        logic [7:0] dout [4];
        int         n_ok;
        int         n_err;
        logic [1:0] code;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        int         ok0;
        int         err0;
        int         kind;
        int         len;
        logic [7:0] jb;

        // Checksums satisfy LEN + payload + CSUM == 0 mod 256 (03+11+22+33 = 69, 69+97 = 100).
        vecs[0] = '{"good3",   6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 8'h00, 8'h00},
                    3, '{8'h11, 8'h22, 8'h33, 8'h00}, 1, 0, 2'd0};
        vecs[1] = '{"len0",    2, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2'd0};
        vecs[2] = '{"badcsum", 6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98, 8'h00, 8'h00},
                    0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2'd1};
        vecs[3] = '{"junk",    7, '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h7F, 8'h80, 8'h00},
                    1, '{8'h7F, 8'h00, 8'h00, 8'h00}, 1, 0, 2'd1};
        vecs[4] = '{"syncpay", 5, '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hB4, 8'h00, 8'h00, 8'h00},
                    2, '{8'hA5, 8'hA5, 8'h00, 8'h00}, 1, 0, 2'd1};
        vecs[5] = '{"len17",   2, '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2'd0};
        vecs[6] = '{"good3b",  6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 8'h00, 8'h00},
                    3, '{8'h11, 8'h22, 8'h33, 8'h00}, 1, 0, 2'd0};

        idle(3);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            ok0  = ok_seen;
            err0 = err_seen;
            for (int j = 0; j < vecs[i].nout; j++)
                exp_q.push_back({(j == vecs[i].nout - 1), vecs[i].dout[j]});
            for (int j = 0; j < vecs[i].nin; j++) send_byte(vecs[i].din[j]);
            idle(4);
            check({vecs[i].name, "_ok"}, 32'(ok_seen - ok0), 32'(vecs[i].n_ok));
            check({vecs[i].name, "_err"}, 32'(err_seen - err0), 32'(vecs[i].n_err));
            check({vecs[i].name, "_code"}, 32'(err_code), 32'(vecs[i].code));
            check({vecs[i].name, "_drained"}, 32'(exp_q.size()), 32'd0);
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd0);
        end
        exp_code = 2'd0;

        // Commit latency: uncommitted bytes invisible; frame_ok and out_valid rise together.
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("lat_pre_valid", 32'(out_valid), 32'd0);
        send_byte(8'h97);
        check("lat_frame_ok", 32'(frame_ok), 32'd1);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_head", 32'({out_last, out_data}), 32'({1'b0, 8'h11}));
        idle(2);
        check("lat_ok_pulse", 32'(frame_ok), 32'd0);
        out_ready = 1'b1;
        wait_drain("lat_drain");

        // Timeout mid-payload, then recovery.
        ok0  = ok_seen;
        err0 = err_seen;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TO - 4);
        check("to_early", 32'(err_seen - err0), 32'd0);
        for (int n = 0; n < 12 && err_seen == err0; n++) idle(1);
        check("to_err", 32'(err_seen - err0), 32'd1);
        check("to_code", 32'(err_code), 32'd2);
        exp_code = 2'd2;
        build_frame(2, 1'b0);
        send_tx(0);
        idle(4);
        check("to_recover_ok", 32'(ok_seen - ok0), 32'd1);
        wait_drain("to_recover_drain");

        // A byte arriving in the expiry cycle is processed instead of timing out.
        ok0  = ok_seen;
        err0 = err_seen;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TO - 1);
        send_byte(8'h22);
        send_byte(8'hCB);
        idle(4);
        check("race_ok", 32'(ok_seen - ok0), 32'd1);
        check("race_err", 32'(err_seen - err0), 32'd0);
        check("race_code", 32'(err_code), 32'(exp_code));
        wait_drain("race_drain");

        // Two 16-byte frames fill the buffer; a third is refused and its bytes dropped.
        out_ready = 1'b0;
        ok0  = ok_seen;
        err0 = err_seen;
        build_frame(16, 1'b0);
        send_tx(0);
        build_frame(16, 1'b0);
        send_tx(0);
        idle(3);
        check("full_ok", 32'(ok_seen - ok0), 32'd2);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_head", 32'({out_last, out_data}), 32'(exp_q[0]));
        send_byte(SYNC);
        send_byte(8'h05);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(3);
        check("nospace_err", 32'(err_seen - err0), 32'd1);
        check("nospace_code", 32'(err_code), 32'd3);
        exp_code = 2'd3;
        check("nospace_ok", 32'(ok_seen - ok0), 32'd2);
        out_ready = 1'b1;
        wait_drain("full_drain");
        ok0 = ok_seen;
        build_frame(4, 1'b0);
        send_tx(0);
        idle(4);
        check("after_drop_ok", 32'(ok_seen - ok0), 32'd1);
        wait_drain("after_drop_drain");

        // Reset with a committed frame buffered and another frame in flight.
        out_ready = 1'b0;
        build_frame(3, 1'b0);
        send_tx(0);
        idle(2);
        tx_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h04, 8'h11, 8'h22};
        send_tx(0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        exp_code = 2'd0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ok", 32'(frame_ok), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        check("mrst_code", 32'(err_code), 32'd0);
        out_ready = 1'b1;
        ok0 = ok_seen;
        build_frame(5, 1'b0);
        send_tx(0);
        idle(4);
        check("mrst_after_ok", 32'(ok_seen - ok0), 32'd1);
        wait_drain("mrst_drain");

        // Random frames with random gaps and random backpressure.
        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            wait_drain("rnd_drain");
            ok0  = ok_seen;
            err0 = err_seen;
            kind = $urandom_range(0, 9);
            if (kind == 8) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255);
                tx_q = '{SYNC, 8'(len)};
                exp_code = 2'd0;
            end else begin
                len = $urandom_range(1, MAXL);
                build_frame(len, kind == 6 || kind == 7);
                if (kind == 6 || kind == 7) exp_code = 2'd1;
                if (kind == 9) begin
                    for (int j = 0; j < 3; j++) begin
                        jb = 8'($urandom);
                        if (jb == SYNC) jb = 8'h00;
                        tx_q.push_front(jb);
                    end
                end
            end
            send_tx(2);
            idle(3);
            check("rnd_ok", 32'(ok_seen - ok0), (kind <= 5 || kind == 9) ? 32'd1 : 32'd0);
            check("rnd_err", 32'(err_seen - err0), (kind >= 6 && kind <= 8) ? 32'd1 : 32'd0);
            check("rnd_code", 32'(err_code), 32'(exp_code));
        end
        rnd_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        wait_drain("rnd_final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
